// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared 7-segment decode table, digit limits and decode helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] HEX_MAX = 4'hF;

  // Segment patterns {g,f,e,d,c,b,a}, entry 15 first
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    return SEG7_LUT[nibble];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_digit_cnt.sv
// ============================================================================
//  Module   : seg7_digit_cnt
//  Brief    : One 4-bit up/down digit with carry/borrow chaining and load.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_digit_cnt #(
  parameter int BCD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       carry_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       carry_out
);
  import seg7_pkg::*;

  localparam logic [3:0] c_MAX = (BCD != 0) ? BCD_MAX : HEX_MAX;

  logic [3:0] r_count;
  logic       w_at_limit;
  logic [3:0] w_load_val;

  assign w_at_limit = up ? (r_count == c_MAX) : (r_count == 4'd0);
  assign carry_out  = carry_in & w_at_limit;
  assign w_load_val = ((BCD != 0) && (load_val > BCD_MAX)) ? BCD_MAX : load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= w_load_val;
    end else if (en && carry_in) begin
      if (w_at_limit)
        r_count <= up ? 4'd0 : c_MAX;
      else
        r_count <= up ? (r_count + 4'd1) : (r_count - 4'd1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_counter.sv
// ============================================================================
//  Module   : seg7_scan_counter
//  Brief    : Multi-digit up/down counter with scanned 7-segment display drive.
//             Define SEG7_ZERO_BLANK_EN to blank leading zero digits.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_counter #(
  parameter int DIGITS   = 2,
  parameter int BCD      = 0,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel
);
  import seg7_pkg::*;

  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_PRE_W = (SCAN_DIV > 0) ? SCAN_DIV : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX  = c_PRE_W'((64'd1 << SCAN_DIV) - 64'd1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

  logic [DIGITS:0] w_carry;

  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      seg7_digit_cnt #(
        .BCD(BCD)
      ) u_digit (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .carry_in (w_carry[gi]),
        .load     (load),
        .load_val (load_val[4*gi +: 4]),
        .count    (count[4*gi +: 4]),
        .carry_out(w_carry[gi+1])
      );
    end
  endgenerate

  // Carry out of the top digit means every digit sits at its wrap point
  assign tc = en & ~load & w_carry[DIGITS];

  logic [c_PRE_W-1:0] r_pre;
  logic [c_IDX_W-1:0] r_idx;
  logic [DIGITS-1:0]  r_digit_sel;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic [c_PRE_W-1:0] w_pre_next;
  logic [c_IDX_W-1:0] w_idx_next;
  logic [DIGITS-1:0]  w_sel_next;
  logic [DIGITS-1:0]  w_blank;
  logic [3:0]         w_nibble;
  logic               w_blank_sel;
  logic [6:0]         w_seg_next;

  always_comb begin
    w_pre_next = r_pre + 1'b1;
    w_idx_next = r_idx;
    if (r_pre == c_PRE_MAX) begin
      w_pre_next = '0;
      w_idx_next = (r_idx == c_IDX_LAST) ? '0 : (r_idx + 1'b1);
    end
  end

`ifdef SEG7_ZERO_BLANK_EN
  logic w_zero_run;

  // A digit blanks only if it and every digit above it are zero; digit 0 never blanks
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (count[4*i +: 4] == 4'd0);
      w_blank[i] = w_zero_run;
    end
  end
`else
  assign w_blank = '0;
`endif

  // seg is fetched for the index that digit_sel will hold after this edge
  always_comb begin
    w_sel_next  = '0;
    w_nibble    = 4'd0;
    w_blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_next == c_IDX_W'(i)) begin
        w_sel_next[i] = 1'b1;
        w_nibble      = count[4*i +: 4];
        w_blank_sel   = w_blank[i];
      end
    end
    w_seg_next = w_blank_sel ? 7'h00 : seg7_decode(w_nibble);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre       <= '0;
      r_idx       <= '0;
      r_digit_sel <= DIGITS'(1);
      r_seg       <= 7'h3F;
      r_dp        <= 1'b0;
    end else begin
      r_pre       <= w_pre_next;
      r_idx       <= w_idx_next;
      r_digit_sel <= w_sel_next;
      r_seg       <= w_seg_next;
      r_dp        <= (w_idx_next == '0) & ~up;
    end
  end

  assign digit_sel = r_digit_sel;
  assign seg       = r_seg;
  assign dp        = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_counter.sv
// ============================================================================
//  Module   : tb_seg7_scan_counter
//  Brief    : Directed vector bench for the scanned 7-segment counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_counter;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [7:0]  lv8;
  logic [11:0] lv12;

  logic [7:0]  b_cnt, h_cnt;
  logic [11:0] d_cnt;
  logic        b_tc, h_tc, d_tc;
  logic [6:0]  b_seg, h_seg, d_seg;
  logic        b_dp, h_dp, d_dp;
  logic [1:0]  b_sel, h_sel;
  logic [2:0]  d_sel;

  always #5 clk = ~clk;

  seg7_scan_counter #(.DIGITS(2), .BCD(1), .SCAN_DIV(2)) u_bcd (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv8),
    .count(b_cnt), .tc(b_tc), .seg(b_seg), .dp(b_dp), .digit_sel(b_sel));

  seg7_scan_counter #(.DIGITS(2), .BCD(0), .SCAN_DIV(2)) u_hex (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv8),
    .count(h_cnt), .tc(h_tc), .seg(h_seg), .dp(h_dp), .digit_sel(h_sel));

  seg7_scan_counter #(.DIGITS(3), .BCD(0), .SCAN_DIV(2)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv12),
    .count(d_cnt), .tc(d_tc), .seg(d_seg), .dp(d_dp), .digit_sel(d_sel));

  typedef struct {
    logic       ld;
    logic [7:0] val;
    logic       e;
    logic       u;
    logic [7:0] b_cnt;
    logic       b_tc;
    logic [7:0] h_cnt;
    logic       h_tc;
  } vec_t;

  vec_t       vecs[18];
  logic [6:0] lut[16];
  int         checks = 0;
  int         errors = 0;
  int         k;

`ifdef SEG7_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_ZERO = 7'h00;
`else
  localparam logic [6:0] LEAD_ZERO = 7'h3F;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Walks the 3-digit display for n edges, checking select, segments and dp
  task automatic scan_check(input int n, input logic [3:0] d0, input logic [6:0] s1,
                            input logic [6:0] s2, input bit chk_dp);
    int idx;
    for (int j = 0; j < n; j++) begin
      tick();
      idx = (k / 4) % 3;
      chk($sformatf("scan k%0d sel", k), 32'(d_sel), 32'(3'b001 << idx));
      chk($sformatf("scan k%0d seg", k), 32'(d_seg),
          32'((idx == 0) ? lut[d0] : ((idx == 1) ? s1 : s2)));
      if (chk_dp)
        chk($sformatf("scan k%0d dp", k), 32'(d_dp), 32'(idx == 0));
    end
  endtask

  initial begin
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0]  = '{1'b1, 8'h98, 1'b1, 1'b1, 8'h98, 1'b0, 8'h98, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h9A, 1'b0};
    vecs[3]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h99, 1'b0, 8'hFF, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1, 8'hFF, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h98, 1'b0, 8'hFE, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h98, 1'b0, 8'hFE, 1'b0};
    vecs[8]  = '{1'b1, 8'hA7, 1'b1, 1'b1, 8'h97, 1'b0, 8'hA7, 1'b0};
    vecs[9]  = '{1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0};
    vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1, 8'hFF, 1'b1};
    vecs[15] = '{1'b1, 8'h09, 1'b0, 1'b1, 8'h09, 1'b0, 8'h09, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 8'h0A, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 8'h09, 1'b0};

    k = 0;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv8 = 8'h00; lv12 = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst b_cnt", 32'(b_cnt), 32'h00);
    chk("rst b_sel", 32'(b_sel), 32'h1);
    chk("rst b_seg", 32'(b_seg), 32'h3F);
    chk("rst b_dp",  32'(b_dp),  32'h0);
    chk("rst b_tc",  32'(b_tc),  32'h0);
    chk("rst h_sel", 32'(h_sel), 32'h1);
    chk("rst h_seg", 32'(h_seg), 32'h3F);
    chk("rst h_dp",  32'(h_dp),  32'h0);
    chk("rst d_sel", 32'(d_sel), 32'h1);
    chk("rst d_cnt", 32'(d_cnt), 32'h000);
    chk("rst d_tc",  32'(d_tc),  32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      load = vecs[i].ld; lv8 = vecs[i].val; lv12 = {4'h0, vecs[i].val};
      en = vecs[i].e; up = vecs[i].u;
      #1;
      chk($sformatf("v%0d b_tc", i), 32'(b_tc), 32'(vecs[i].b_tc));
      chk($sformatf("v%0d h_tc", i), 32'(h_tc), 32'(vecs[i].h_tc));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d b_cnt", i), 32'(b_cnt), 32'(vecs[i].b_cnt));
      chk($sformatf("v%0d h_cnt", i), 32'(h_cnt), 32'(vecs[i].h_cnt));
    end

    // Scan timing on the 3-digit instance, k counts edges since reset
    @(negedge clk);
    reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0;
    @(posedge clk);
    #1;
    k = 0;
    chk("scan rst sel", 32'(d_sel), 32'h1);
    chk("scan rst seg", 32'(d_seg), 32'h3F);
    chk("scan rst dp",  32'(d_dp),  32'h0);
    @(negedge clk);
    reset = 1'b0; load = 1'b1; lv12 = 12'h5A3;
    tick();
    chk("load cnt",     32'(d_cnt), 32'h5A3);
    chk("load seg lag", 32'(d_seg), 32'h3F);
    chk("load sel",     32'(d_sel), 32'h1);
    chk("load dp",      32'(d_dp),  32'h1);
    @(negedge clk);
    load = 1'b0;
    scan_check(13, 4'h3, lut[4'hA], lut[4'h5], 1'b1);

    @(negedge clk);
    load = 1'b1; lv12 = 12'h005;
    tick();
    chk("load005 cnt", 32'(d_cnt), 32'h005);
    @(negedge clk);
    load = 1'b0;
    scan_check(12, 4'h5, LEAD_ZERO, LEAD_ZERO, 1'b0);

    @(negedge clk);
    load = 1'b1; lv12 = 12'h000;
    tick();
    @(negedge clk);
    load = 1'b0;
    scan_check(12, 4'h0, LEAD_ZERO, LEAD_ZERO, 1'b0);

    // Reset in the middle of the digit-1 slot
    while ((k / 4) % 3 != 1) tick();
    chk("pre-reset sel", 32'(d_sel), 32'h2);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midscan sel", 32'(d_sel), 32'h1);
    chk("midscan seg", 32'(d_seg), 32'h3F);
    chk("midscan dp",  32'(d_dp),  32'h0);
    chk("midscan cnt", 32'(d_cnt), 32'h000);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
